// File: rtl/mem_io_responder.sv
// Wait-stated CPU memory/IO responder: word RAM, LED register, switch port.
// Define MEMIO_BTNCNT_EN to add the btn[0] press counter at 0xF000_0008.
module mem_io_responder #(
   parameter int RAM_AW = 8,
   parameter int WAIT   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_req,
   input  logic [31:0] m_addr,
   input  logic        w_d_mem,
   input  logic [31:0] d_t_mem,
   output logic [31:0] d_f_mem,
   output logic        m_ready,
   input  logic [7:0]  sw,
   input  logic [4:0]  btn,
   output logic [7:0]  Led
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state, state_nxt;
   logic [3:0]        wcnt;
   logic [31:2]       addr_q;
   logic              we_q;
   logic [31:0]       data_q;
   logic [31:0]       ram [2**RAM_AW];
   logic [31:0]       ram_q;
   logic [RAM_AW-1:0] rd_idx;
   logic [31:0]       rd_data;
   logic              sel_ram, sel_led, sel_sw, commit;

   assign sel_ram = addr_q[31:28] == 4'h0;
   assign sel_led = addr_q == 30'h3C00_0000;
   assign sel_sw  = addr_q == 30'h3C00_0001;
   // a reset in the RESP cycle suppresses the write
   assign commit  = state == S_RESP && we_q && !rst;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (m_req) state_nxt = (WAIT == 0) ? S_RESP : S_WAIT;
         S_WAIT:  if (wcnt == 4'd1) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      m_ready = 1'b0;
      d_f_mem = 32'h0;
      if (state == S_RESP && !rst) begin
         m_ready = 1'b1;
         d_f_mem = rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && m_req) begin
         addr_q <= m_addr[31:2];
         we_q   <= w_d_mem;
         data_q <= d_t_mem;
      end
      if (state == S_IDLE)      wcnt <= 4'(WAIT);
      else if (state == S_WAIT) wcnt <= wcnt - 4'd1;
   end

   // In IDLE the read port follows the bus so the word is ready even with no wait states.
   assign rd_idx = (state == S_IDLE) ? m_addr[RAM_AW+1:2] : addr_q[RAM_AW+1:2];

   always_ff @(posedge clk) begin
      if (commit && sel_ram) ram[addr_q[RAM_AW+1:2]] <= data_q;
      ram_q <= ram[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst)                   Led <= 8'h0;
      else if (commit && sel_led) Led <= data_q[7:0];
   end

`ifdef MEMIO_BTNCNT_EN
   logic       sel_cnt, btn_prev;
   logic [7:0] bcnt;
   logic       unused;

   assign sel_cnt = addr_q == 30'h3C00_0002;
   assign unused  = ^{btn[4:1], m_addr[1:0]};

   // a clear wins over a coincident press
   always_ff @(posedge clk) begin
      if (rst) begin
         bcnt     <= 8'h0;
         btn_prev <= 1'b0;
      end else begin
         btn_prev <= btn[0];
         if (commit && sel_cnt)      bcnt <= 8'h0;
         else if (btn[0] && !btn_prev) bcnt <= bcnt + 8'd1;
      end
   end
`else
   logic unused;
   assign unused = ^{btn, m_addr[1:0]};
`endif

   always_comb begin
      rd_data = 32'hDEAD_BEEF;
      if (sel_ram)      rd_data = ram_q;
      else if (sel_led) rd_data = {24'h0, Led};
      else if (sel_sw)  rd_data = {24'h0, sw};
`ifdef MEMIO_BTNCNT_EN
      else if (sel_cnt) rd_data = {24'h0, bcnt};
`endif
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized bench for mem_io_responder against an address-map reference model.
// Main instance uses WAIT=1; a second WAIT=0 instance covers back-to-back requests.
module tb_mem_io_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, m_req, m_req0, w_d_mem, m_ready, m_ready0;
   logic [31:0] m_addr, d_t_mem, d_f_mem, d_f_mem0;
   logic [7:0]  sw, Led, led0;
   logic [4:0]  btn;

   int checks = 0, errors = 0;
   logic [31:0] mem_m [256];
   logic [7:0]  led_m, cnt_m;

   mem_io_responder #(.RAM_AW(8), .WAIT(1)) dut (
      .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .w_d_mem(w_d_mem),
      .d_t_mem(d_t_mem), .d_f_mem(d_f_mem), .m_ready(m_ready), .sw(sw), .btn(btn), .Led(Led));

   mem_io_responder #(.RAM_AW(4), .WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .m_req(m_req0), .m_addr(m_addr), .w_d_mem(w_d_mem),
      .d_t_mem(d_t_mem), .d_f_mem(d_f_mem0), .m_ready(m_ready0), .sw(sw), .btn(btn), .Led(led0));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (a[31:28] == 4'h0)         return mem_m[a[9:2]];
      if (a[31:2] == 30'h3C00_0000) return {24'h0, led_m};
      if (a[31:2] == 30'h3C00_0001) return {24'h0, sw};
`ifdef MEMIO_BTNCNT_EN
      if (a[31:2] == 30'h3C00_0002) return {24'h0, cnt_m};
`endif
      return 32'hDEAD_BEEF;
   endfunction

   task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
      if (a[31:28] == 4'h0)         mem_m[a[9:2]] = d;
      if (a[31:2] == 30'h3C00_0000) led_m = d[7:0];
`ifdef MEMIO_BTNCNT_EN
      if (a[31:2] == 30'h3C00_0002) cnt_m = 8'h0;
`endif
   endtask

   // One bus access on the main instance, starting and ending in an IDLE cycle.
   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input bit edge_in_resp, output logic [31:0] rd, output int lat);
      @(negedge clk);
      m_req = 1'b1; w_d_mem = we; m_addr = a; d_t_mem = d;
      @(posedge clk); #1;
      lat = 1;
      m_addr = $urandom; d_t_mem = $urandom; w_d_mem = ~we;
      while (!m_ready && lat < 20) begin
         chk("dfm_wait", d_f_mem, 32'h0);
         @(posedge clk); #1;
         lat++;
      end
      rd = d_f_mem;
      m_req = 1'b0;
      if (edge_in_resp) btn[0] = 1'b1;
      @(posedge clk); #1;
      chk("rdy_pulse", {31'h0, m_ready}, 32'h0);
      chk("dfm_after", d_f_mem, 32'h0);
   endtask

   task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rd, exp;
      int lat;
      exp = model_rd(a);
      access(we, a, d, 1'b0, rd, lat);
      chk("latency", 32'(lat), 32'd2);
      if (we) model_wr(a, d);
      else    chk($sformatf("rd_%h", a), rd, exp);
      chk("led", {24'h0, Led}, {24'h0, led_m});
   endtask

   task automatic pulse();
      @(negedge clk); btn[0] = 1'b1;
      @(negedge clk); btn[0] = 1'b0;
      cnt_m = cnt_m + 8'd1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, old;
      int lat, pulses, consec;
      logic prev;

      rst = 1'b1; m_req = 1'b0; m_req0 = 1'b0; w_d_mem = 1'b0;
      m_addr = 32'h0; d_t_mem = 32'h0; sw = 8'h3C; btn = 5'h0;
      led_m = 8'h0; cnt_m = 8'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", {31'h0, m_ready}, 32'h0);
      chk("rst_dfm", d_f_mem, 32'h0);
      chk("rst_led", {24'h0, Led}, 32'h0);
      chk("rst_rdy0", {31'h0, m_ready0}, 32'h0);
      chk("rst_led0", {24'h0, led0}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) xact(1'b1, 32'(i * 4), $urandom);

      // directed map checks
      xact(1'b1, 32'h0000_0010, 32'h1234_5678);
      xact(1'b0, 32'h0000_0010, 32'h0);
      xact(1'b0, 32'h0ABC_D410, 32'h0);
      xact(1'b1, 32'hF000_0000, 32'hFFFF_FFA5);
      xact(1'b0, 32'hF000_0000, 32'h0);
      xact(1'b0, 32'hF000_0003, 32'h0);
      xact(1'b0, 32'hF000_0004, 32'h0);
      xact(1'b1, 32'hF000_0004, 32'hFFFF_FFFF);
      xact(1'b0, 32'hF000_0004, 32'h0);
      xact(1'b0, 32'h8000_0000, 32'h0);
      xact(1'b1, 32'h8000_0000, 32'h0000_0001);
      xact(1'b0, 32'h8000_0000, 32'h0);

      for (int n = 0; n < 80; n++) begin
         logic [31:0] r, a, d;
         logic we;
         int k;
         r = $urandom; d = $urandom; k = $urandom_range(0, 5);
         we = 1'($urandom_range(0, 1));
         case (k)
            0, 1: a = {4'h0, r[27:10], 4'h0, r[5:0]};
            2:    a = {30'h3C00_0000, r[1:0]};
            3:    a = {30'h3C00_0001, r[1:0]};
            4:    a = {30'h3C00_0002, r[1:0]};
            default: a = r[31] ? {4'h1 + {1'b0, r[30:28]}, r[27:0]}
                               : {4'hF, r[27:4] | 24'h1, r[3:0]};
         endcase
         if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
         if ($urandom_range(0, 3) == 0) pulse();
         xact(we, a, d);
      end

      // counter wrap and clear-vs-edge priority
      xact(1'b1, 32'hF000_0008, 32'h0);
      cnt_m = 8'h0;
      repeat (257) pulse();
      xact(1'b0, 32'hF000_0008, 32'h0);
      repeat (3) pulse();
      access(1'b1, 32'hF000_0008, 32'h55, 1'b1, rd, lat);
      chk("clr_latency", 32'(lat), 32'd2);
      model_wr(32'hF000_0008, 32'h55);
      @(negedge clk); btn[0] = 1'b0;
      xact(1'b0, 32'hF000_0008, 32'h0);

      // reset during WAIT aborts the write
      xact(1'b1, 32'hF000_0000, 32'h5A);
      old = mem_m[8];
      @(negedge clk);
      m_req = 1'b1; w_d_mem = 1'b1; m_addr = 32'h0000_0020; d_t_mem = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      rst = 1'b1; m_req = 1'b0;
      chk("abort_w_rdy", {31'h0, m_ready}, 32'h0);
      @(posedge clk); #1;
      chk("abort_w_rdy2", {31'h0, m_ready}, 32'h0);
      chk("abort_led", {24'h0, Led}, 32'h0);
      led_m = 8'h0; cnt_m = 8'h0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_w_rdy3", {31'h0, m_ready}, 32'h0);
      xact(1'b0, 32'h0000_0020, 32'h0);
      chk("abort_w_mem", model_rd(32'h20), old);

      // reset during RESP also suppresses the write and the pulse
      old = mem_m[9];
      @(negedge clk);
      m_req = 1'b1; w_d_mem = 1'b1; m_addr = 32'h0000_0024; d_t_mem = ~old;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("resp_seen", {31'h0, m_ready}, 32'h1);
      rst = 1'b1; m_req = 1'b0;
      #1;
      chk("resp_rst_rdy", {31'h0, m_ready}, 32'h0);
      chk("resp_rst_dfm", d_f_mem, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      xact(1'b0, 32'h0000_0024, 32'h0);

      // zero-wait instance with a request held high
      @(negedge clk);
      m_addr = 32'hF000_0004; w_d_mem = 1'b0; sw = 8'h96; m_req0 = 1'b1;
      prev = 1'b0; pulses = 0; consec = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (m_ready0) begin
            pulses++;
            if (prev) consec++;
            chk("dut0_rd", d_f_mem0, {24'h0, sw});
         end else begin
            chk("dut0_dfz", d_f_mem0, 32'h0);
         end
         prev = m_ready0;
      end
      m_req0 = 1'b0;
      chk("dut0_pulses", 32'(pulses), 32'd10);
      chk("dut0_consec", 32'(consec), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
